// File: rtl/sop_sweep_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sop_sweep_checker_pkg
//  Description : Shared definitions for the SOP sweep checker: FSM state
//                encodings, golden truth table, sweep length and the
//                lowest-set-bit encoder used to locate the first mismatch.
//  Revision    : 1.0  initial release
// ============================================================================
package sop_sweep_checker_pkg;

    // Sweep FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    // Golden truth table of f = ~x&~z | ~y&z, bit i = f for {x,y,z} = i
    localparam logic [7:0] SOP_GOLDEN = 8'h27;

    // Number of input vectors in one sweep
    localparam int SWEEP_LEN = 8;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sop_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sop_settle_timer
//  Description : Loadable down-counter that stops at zero and flags it.
//                Drives the settle window between vector drive and sample.
//  Revision    : 1.0  initial release
// ============================================================================
module sop_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] r_cnt;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign zero = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/sop_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sop_sweep_checker
//  Description : Drives x,y,z through all 8 combinations, waits a settle
//                window per vector, captures f into a truth table and compares
//                it with the golden table, reporting pass and the lowest
//                failing index.
//  Revision    : 1.0  initial release
// ============================================================================
module sop_sweep_checker
    import sop_sweep_checker_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] EXPECTED      = SOP_GOLDEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       pass,
    output logic [2:0] fail_idx
);

    localparam logic [2:0] c_last_idx = 3'(SWEEP_LEN - 1);
    localparam logic [3:0] c_settle   = 4'(SETTLE_CYCLES);

    sweep_state_t r_state;
    sweep_state_t w_state_nxt;
    logic         w_load;
    logic         w_zero;
    logic [2:0]   r_idx;
    logic [2:0]   r_xyz;
    logic [7:0]   r_result;
    logic         r_pass;
    logic [2:0]   r_fail_idx;
    logic [7:0]   w_result_nxt;

    sop_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (c_settle),
        .zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and settle-timer reload
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Truth table with the current sample merged in, so the final compare
    // sees bit 7 in the same cycle it is captured
    always_comb begin
        w_result_nxt        = r_result;
        w_result_nxt[r_idx] = f;
    end

    // Vector index, stimulus, capture register and verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= 3'd0;
            r_xyz      <= 3'd0;
            r_result   <= 8'h00;
            r_pass     <= 1'b0;
            r_fail_idx <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx      <= 3'd0;
                        r_xyz      <= 3'd0;
                        r_result   <= 8'h00;
                        r_pass     <= 1'b0;
                        r_fail_idx <= 3'd0;
                    end
                end
                ST_SAMPLE: begin
                    r_result <= w_result_nxt;
                    if (r_idx == c_last_idx) begin
                        r_pass     <= (w_result_nxt == EXPECTED);
                        r_fail_idx <= lowest_set_idx(w_result_nxt ^ EXPECTED);
                    end else begin
                        r_idx <= r_idx + 3'd1;
                        r_xyz <= r_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {x, y, z} = r_xyz;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign pass      = r_pass;
    assign fail_idx  = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_sop_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sop_sweep_checker
//  Description : Directed self-checking bench for sop_sweep_checker with a
//                behavioural SOP block (optionally faulted) in the loop, plus a
//                second instance with a zero-length settle window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sop_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       f;
    logic       x, y, z;
    logic       busy, done, pass;
    logic [7:0] result;
    logic [2:0] fail_idx;

    logic       start0;
    logic       f0;
    logic       x0, y0, z0;
    logic       busy0, done0, pass0;
    logic [7:0] result0;
    logic [2:0] fail_idx0;

    // f source select: 0 real SOP, 1 stuck 0, 2 stuck 1, 3 SOP inverted at index 5
    int mode;

    int n_checks;
    int n_errors;

    sop_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(8'h27)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .f        (f),
        .x        (x),
        .y        (y),
        .z        (z),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .pass     (pass),
        .fail_idx (fail_idx)
    );

    sop_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(8'h27)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .f        (f0),
        .x        (x0),
        .y        (y0),
        .z        (z0),
        .busy     (busy0),
        .done     (done0),
        .result   (result0),
        .pass     (pass0),
        .fail_idx (fail_idx0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SOP block and fault injection
    always_comb begin
        logic sop;
        sop = (~x & ~z) | (~y & z);
        case (mode)
            1:       f = 1'b0;
            2:       f = 1'b1;
            3:       f = sop ^ ({x, y, z} == 3'd5);
            default: f = sop;
        endcase
    end

    assign f0 = (~x0 & ~z0) | (~y0 & z0);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start at edge 0, then watch 40 edges; optional extra start
    // pulse sampled at edge restart_at
    task automatic run_sweep(input int restart_at, output int done_edge,
                             output int n_done, output int busy_drop);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_edge = -1;
        n_done    = 0;
        busy_drop = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = k;
            end
            if ((done_edge < 0 || done_edge == k) && !busy) busy_drop++;
        end
    endtask

    initial begin
        int de, nd, bd, de2;
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        start    = 1'b0;
        start0   = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_xyz",   32'({x, y, z}), 32'd0);
        check("rst_res",   32'(result), 32'h00);
        check("rst_pass",  32'(pass), 32'd0);
        check("rst_fidx",  32'(fail_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. Real SOP in loop
        run_sweep(-1, de, nd, bd);
        check("t1_done_edge", 32'(de), 32'd24);
        check("t1_done_cnt",  32'(nd), 32'd1);
        check("t1_busy",      32'(bd), 32'd0);
        check("t1_res",       32'(result), 32'h27);
        check("t1_pass",      32'(pass), 32'd1);
        check("t1_fidx",      32'(fail_idx), 32'd0);
        check("t1_xyz_hold",  32'({x, y, z}), 32'd7);
        check("t1_idle",      32'(busy), 32'd0);

        // 2. f stuck at 0, then stuck at 1
        mode = 1;
        run_sweep(-1, de, nd, bd);
        check("t2a_res",  32'(result), 32'h00);
        check("t2a_pass", 32'(pass), 32'd0);
        check("t2a_fidx", 32'(fail_idx), 32'd0);
        mode = 2;
        run_sweep(-1, de, nd, bd);
        check("t2b_res",  32'(result), 32'hFF);
        check("t2b_pass", 32'(pass), 32'd0);
        check("t2b_fidx", 32'(fail_idx), 32'd3);

        // 3. Single-index fault at 5
        mode = 3;
        run_sweep(-1, de, nd, bd);
        check("t3_res",  32'(result), 32'h07);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_fidx", 32'(fail_idx), 32'd5);

        // 4. Extra start at edge 10 is ignored
        mode = 0;
        run_sweep(10, de, nd, bd);
        check("t4_done_edge", 32'(de), 32'd24);
        check("t4_done_cnt",  32'(nd), 32'd1);
        check("t4_busy",      32'(bd), 32'd0);
        check("t4_res",       32'(result), 32'h27);

        // 5. Reset at edge 12 aborts the sweep
        mode = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_xyz",  32'({x, y, z}), 32'd0);
        check("t5_res",  32'(result), 32'h00);
        check("t5_done", 32'(done), 32'd0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) nd++;
        end
        check("t5_no_done", 32'(nd), 32'd0);
        mode = 0;
        run_sweep(-1, de, nd, bd);
        check("t5_done_edge", 32'(de), 32'd24);
        check("t5_res2",      32'(result), 32'h27);
        check("t5_pass2",     32'(pass), 32'd1);

        // 6. Zero settle window, start held high for back-to-back sweeps
        start0 = 1'b1;
        tick();
        check("t6_xyz_0", 32'({x0, y0, z0}), 32'd0);
        de  = -1;
        de2 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k < 16) check($sformatf("t6_xyz_%0d", k), 32'({x0, y0, z0}), 32'(k / 2));
            if (done0) begin
                if (de < 0) begin
                    de = k;
                    check("t6_res",  32'(result0), 32'h27);
                    check("t6_pass", 32'(pass0), 32'd1);
                end else if (de2 < 0) begin
                    de2 = k;
                end
            end
        end
        start0 = 1'b0;
        check("t6_done1", 32'(de), 32'd16);
        check("t6_done2", 32'(de2), 32'd34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
